uart_rx_buffered: RTL and testbench

//   Parametrised UART receiver with a tagged receive FIFO. Next generation of the single-byte uart RX path.

---
 rtl/uart_rx_buffered.sv | 203 ++++++++++++++++++++
 tb/tb_uart_rx_buffered.sv | 306 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_buffered.sv
// UART receiver with runtime parity/stop-bit options, feeding a show-ahead FIFO whose
// entries carry per-word parity and frame error tags alongside the data.
module uart_rx_buffered #(
  parameter int CLKS_PER_BIT = 5208,
  parameter int DATA_BITS    = 8,
  parameter int FIFO_DEPTH   = 16
) (
  input  logic                                 clock,
  input  logic                                 reset,
  input  logic                                 serial_in,
  input  logic [7:0]                           usr_options,
  input  logic                                 data_read,
  output logic [DATA_BITS-1:0]                 data_out,
  output logic                                 parity_error,
  output logic                                 frame_error,
  output logic                                 new_data,
  output logic                                 overrun,
  input  logic                                 clear_overrun,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]      fifo_count
);

  localparam int CNT_W  = $clog2(CLKS_PER_BIT);
  localparam int BIT_W  = $clog2(DATA_BITS);
  localparam int PTR_W  = $clog2(FIFO_DEPTH);
  localparam int FCNT_W = $clog2(FIFO_DEPTH+1);
  localparam int WORD_W = DATA_BITS + 2;

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, WAIT_HIGH} state_t;

  state_t               state, state_d;
  logic [1:0]           sync_q;
  logic                 rx;
  logic [CNT_W-1:0]     cnt, cnt_d;
  logic [BIT_W-1:0]     bit_idx, bit_idx_d;
  logic [DATA_BITS-1:0] shift, shift_d;
  logic [2:0]           opts, opts_d;
  logic                 stop2, stop2_d;
  logic                 perr, perr_d;
  logic                 ferr, ferr_d;
  logic                 push;
  logic [WORD_W-1:0]    push_word;
  logic                 unused_opts;

  assign unused_opts = ^usr_options[4:0];
  assign rx = sync_q[1];

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      sync_q  <= 2'b11;
      state   <= IDLE;
      cnt     <= '0;
      bit_idx <= '0;
      shift   <= '0;
      opts    <= '0;
      stop2   <= 1'b0;
      perr    <= 1'b0;
      ferr    <= 1'b0;
    end else begin
      sync_q  <= {sync_q[0], serial_in};
      state   <= state_d;
      cnt     <= cnt_d;
      bit_idx <= bit_idx_d;
      shift   <= shift_d;
      opts    <= opts_d;
      stop2   <= stop2_d;
      perr    <= perr_d;
      ferr    <= ferr_d;
    end
  end

  // opts = {parity enable, odd parity, two stop bits}, frozen for the whole frame at start detection
  always_comb begin
    state_d   = state;
    cnt_d     = cnt;
    bit_idx_d = bit_idx;
    shift_d   = shift;
    opts_d    = opts;
    stop2_d   = stop2;
    perr_d    = perr;
    ferr_d    = ferr;
    push      = 1'b0;
    push_word = {ferr | ~rx, perr, shift};
    case (state)
      IDLE: begin
        if (!rx) begin
          opts_d    = usr_options[7:5];
          cnt_d     = CNT_W'(CLKS_PER_BIT/2 - 1);
          bit_idx_d = '0;
          stop2_d   = 1'b0;
          perr_d    = 1'b0;
          ferr_d    = 1'b0;
          state_d   = START;
        end
      end
      START: begin
        if (cnt == '0) begin
          if (!rx) begin
            cnt_d   = CNT_W'(CLKS_PER_BIT - 1);
            state_d = DATA;
          end else begin
            state_d = IDLE;
          end
        end else begin
          cnt_d = cnt - CNT_W'(1);
        end
      end
      DATA: begin
        if (cnt == '0) begin
          shift_d = {rx, shift[DATA_BITS-1:1]};
          cnt_d   = CNT_W'(CLKS_PER_BIT - 1);
          if (bit_idx == BIT_W'(DATA_BITS - 1))
            state_d = opts[2] ? PARITY : STOP;
          else
            bit_idx_d = bit_idx + BIT_W'(1);
        end else begin
          cnt_d = cnt - CNT_W'(1);
        end
      end
      PARITY: begin
        if (cnt == '0) begin
          perr_d  = opts[1] ? ~^{shift, rx} : ^{shift, rx};
          cnt_d   = CNT_W'(CLKS_PER_BIT - 1);
          state_d = STOP;
        end else begin
          cnt_d = cnt - CNT_W'(1);
        end
      end
      STOP: begin
        if (cnt == '0) begin
          ferr_d = ferr | ~rx;
          if (opts[0] && !stop2) begin
            stop2_d = 1'b1;
            cnt_d   = CNT_W'(CLKS_PER_BIT - 1);
          end else begin
            push    = 1'b1;
            state_d = rx ? IDLE : WAIT_HIGH;
          end
        end else begin
          cnt_d = cnt - CNT_W'(1);
        end
      end
      WAIT_HIGH: begin
        if (rx) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  logic [WORD_W-1:0] mem [FIFO_DEPTH];
  logic [WORD_W-1:0] head, head_d;
  logic [PTR_W-1:0]  wr_ptr, rd_ptr, rd_next;
  logic [FCNT_W-1:0] count, count_d;
  logic              full, do_pop, do_push, drop;

  assign full    = (count == FCNT_W'(FIFO_DEPTH));
  assign do_pop  = data_read && (count != '0);
  assign do_push = push && (!full || do_pop);
  assign drop    = push && full && !do_pop;
  assign rd_next = do_pop ? rd_ptr + PTR_W'(1) : rd_ptr;

  // The head register keeps its old value once the FIFO drains, so data_out holds the last word read
  always_comb begin
    count_d = count;
    case ({do_push, do_pop})
      2'b10:   count_d = count + FCNT_W'(1);
      2'b01:   count_d = count - FCNT_W'(1);
      default: count_d = count;
    endcase
    head_d = head;
    if (count_d != '0)
      head_d = (do_push && wr_ptr == rd_next) ? push_word : mem[rd_next];
  end

  always_ff @(posedge clock) begin
    if (do_push) mem[wr_ptr] <= push_word;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count   <= '0;
      head    <= '0;
      overrun <= 1'b0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
      rd_ptr <= rd_next;
      count  <= count_d;
      head   <= head_d;
      if (drop)
        overrun <= 1'b1;
      else if (clear_overrun)
        overrun <= 1'b0;
    end
  end

  assign data_out     = head[DATA_BITS-1:0];
  assign parity_error = head[DATA_BITS];
  assign frame_error  = head[DATA_BITS+1];
  assign new_data     = (count != '0);
  assign fifo_count   = count;

endmodule

// File: tb/tb_uart_rx_buffered.sv
// Bench for uart_rx_buffered: serial frames built from random data/options, expected words
// derived from the UART framing rules and tracked in a queue modelling the receive FIFO.
module tb_uart_rx_buffered;
  localparam int CPB   = 16;
  localparam int DB    = 8;
  localparam int DEPTH = 4;

  logic       clock;
  logic       reset;
  logic       serial_in;
  logic [7:0] usr_options;
  logic       data_read;
  logic [7:0] data_out;
  logic       parity_error;
  logic       frame_error;
  logic       new_data;
  logic       overrun;
  logic       clear_overrun;
  logic [2:0] fifo_count;

  uart_rx_buffered #(.CLKS_PER_BIT(CPB), .DATA_BITS(DB), .FIFO_DEPTH(DEPTH)) dut (
    .clock(clock), .reset(reset), .serial_in(serial_in), .usr_options(usr_options),
    .data_read(data_read), .data_out(data_out), .parity_error(parity_error),
    .frame_error(frame_error), .new_data(new_data), .overrun(overrun),
    .clear_overrun(clear_overrun), .fifo_count(fifo_count)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int         total = 0;
  int         bad   = 0;
  logic [9:0] model_q[$];
  bit         model_over = 0;
  logic [9:0] w, e, seen;

  // Expected FIFO word {frame_err, parity_err, data} from the frame's content alone
  function automatic logic [9:0] exp_word(input logic [7:0] d, input logic [7:0] opts,
                                          input bit pbit, input bit stop_lvl);
    int ones;
    bit perr;
    ones = $countones(d) + (opts[7] ? int'(pbit) : 0);
    if (!opts[7])     perr = 1'b0;
    else if (opts[6]) perr = (ones % 2 == 0);
    else              perr = (ones % 2 == 1);
    return {!stop_lvl, perr, d};
  endfunction

  task automatic model_push(input logic [9:0] word);
    if (model_q.size() < DEPTH) model_q.push_back(word);
    else model_over = 1'b1;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clock);
  endtask

  // Drives one frame; the last stop sample lands 3 + CPB/2 cycles into the frame plus whole bits
  task automatic send_frame(input logic [7:0] d, input logic [7:0] opts, input bit pbit,
                            input bit stop_lvl, input bit pop_at_push, input bit scramble,
                            output logic [9:0] head_seen);
    bit bits[$];
    int push_cyc;
    int cyc;
    bits.push_back(1'b0);
    for (int i = 0; i < DB; i++) bits.push_back(d[i]);
    if (opts[7]) bits.push_back(pbit);
    bits.push_back(stop_lvl);
    if (opts[5]) bits.push_back(stop_lvl);
    push_cyc  = 3 + CPB/2 + CPB * (bits.size() - 1);
    cyc       = 0;
    head_seen = '0;
    usr_options = opts;
    foreach (bits[b]) begin
      serial_in = bits[b];
      repeat (CPB) begin
        if (scramble && cyc == 24) usr_options = 8'($urandom);
        if (pop_at_push && cyc == push_cyc - 1) begin
          head_seen = {frame_error, parity_error, data_out};
          data_read = 1'b1;
        end else begin
          data_read = 1'b0;
        end
        @(negedge clock);
        cyc++;
      end
    end
    data_read = 1'b0;
  endtask

  task automatic pop_word(output logic [9:0] word);
    word = {frame_error, parity_error, data_out};
    data_read = 1'b1;
    @(negedge clock);
    data_read = 1'b0;
  endtask

  task automatic test_reset;
    logic [14:0] obs;
    reset = 1'b0; serial_in = 1'b1; usr_options = '0; data_read = 0; clear_overrun = 0;
    idle(3);
    obs = {data_out, parity_error, frame_error, new_data, overrun, fifo_count};
    total++;
    if (obs !== 15'd0) begin bad++; $display("FAIL reset_outputs got=%h exp=%h", obs, 15'd0); end
    reset = 1'b1;
    idle(4);
    total++;
    if (new_data !== 1'b0) begin bad++; $display("FAIL reset_release got=%b exp=0", new_data); end
  endtask

  task automatic test_basic;
    send_frame(8'hA5, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0, seen);
    model_push(exp_word(8'hA5, 8'h00, 1'b0, 1'b1));
    idle(2);
    total++;
    if (fifo_count !== 3'd1) begin bad++; $display("FAIL basic_count got=%0d exp=1", fifo_count); end
    total++;
    if (new_data !== 1'b1) begin bad++; $display("FAIL basic_new_data got=%b exp=1", new_data); end
    pop_word(w);
    e = model_q.pop_front();
    total++;
    if (w !== e) begin bad++; $display("FAIL basic_word got=%h exp=%h", w, e); end
    total++;
    if (new_data !== 1'b0) begin bad++; $display("FAIL basic_empty got=%b exp=0", new_data); end
  endtask

  task automatic test_parity;
    logic [7:0] opt_tab[4] = '{8'h80, 8'h80, 8'hC0, 8'hC0};
    bit         pb_tab[4]  = '{1'b0, 1'b1, 1'b0, 1'b1};
    for (int i = 0; i < 4; i++) begin
      send_frame(8'h07, opt_tab[i], pb_tab[i], 1'b1, 1'b0, 1'b0, seen);
      model_push(exp_word(8'h07, opt_tab[i], pb_tab[i], 1'b1));
      idle(2);
      pop_word(w);
      e = model_q.pop_front();
      total++;
      if (w !== e) begin bad++; $display("FAIL parity_case%0d got=%h exp=%h", i, w, e); end
    end
  endtask

  task automatic test_frame;
    send_frame(8'h3C, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, seen);
    model_push(exp_word(8'h3C, 8'h00, 1'b0, 1'b0));
    idle(CPB * 39);
    serial_in = 1'b1;
    idle(32);
    total++;
    if (fifo_count !== 3'(model_q.size())) begin
      bad++; $display("FAIL frame_count got=%0d exp=%0d", fifo_count, model_q.size());
    end
    pop_word(w);
    e = model_q.pop_front();
    total++;
    if (w !== e) begin bad++; $display("FAIL frame_word got=%h exp=%h", w, e); end
    send_frame(8'h11, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0, seen);
    model_push(exp_word(8'h11, 8'h00, 1'b0, 1'b1));
    idle(2);
    pop_word(w);
    e = model_q.pop_front();
    total++;
    if (w !== e) begin bad++; $display("FAIL frame_next got=%h exp=%h", w, e); end
  endtask

  task automatic test_overrun;
    logic [7:0] d;
    for (int i = 0; i < 5; i++) begin
      d = 8'($urandom);
      send_frame(d, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0, seen);
      model_push(exp_word(d, 8'h00, 1'b0, 1'b1));
    end
    idle(2);
    total++;
    if (fifo_count !== 3'(model_q.size())) begin
      bad++; $display("FAIL ovr_count got=%0d exp=%0d", fifo_count, model_q.size());
    end
    total++;
    if (overrun !== model_over) begin bad++; $display("FAIL ovr_flag got=%b exp=%b", overrun, model_over); end
    for (int i = 0; i < DEPTH; i++) begin
      pop_word(w);
      e = model_q.pop_front();
      total++;
      if (w !== e) begin bad++; $display("FAIL ovr_word%0d got=%h exp=%h", i, w, e); end
    end
    total++;
    if (new_data !== 1'b0) begin bad++; $display("FAIL ovr_drained got=%b exp=0", new_data); end
    total++;
    if (overrun !== model_over) begin bad++; $display("FAIL ovr_sticky got=%b exp=%b", overrun, model_over); end
    clear_overrun = 1'b1;
    @(negedge clock);
    clear_overrun = 1'b0;
    model_over = 1'b0;
    total++;
    if (overrun !== model_over) begin bad++; $display("FAIL ovr_clear got=%b exp=%b", overrun, model_over); end
  endtask

  task automatic test_glitch_reset;
    logic [7:0]  d;
    logic [14:0] obs;
    d = 8'($urandom);
    send_frame(d, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0, seen);
    model_push(exp_word(d, 8'h00, 1'b0, 1'b1));
    serial_in = 1'b0;
    idle(4);
    serial_in = 1'b1;
    idle(CPB * 12);
    total++;
    if (fifo_count !== 3'(model_q.size())) begin
      bad++; $display("FAIL glitch_count got=%0d exp=%0d", fifo_count, model_q.size());
    end
    serial_in = 1'b0; idle(CPB);
    serial_in = 1'b1; idle(CPB);
    serial_in = 1'b0; idle(CPB);
    serial_in = 1'b1; idle(CPB);
    serial_in = 1'b0; idle(CPB / 2);
    reset = 1'b0;
    #1;
    model_q.delete();
    model_over = 1'b0;
    obs = {data_out, parity_error, frame_error, new_data, overrun, fifo_count};
    total++;
    if (obs !== 15'd0) begin bad++; $display("FAIL midframe_reset got=%h exp=%h", obs, 15'd0); end
    idle(3);
    serial_in = 1'b1;
    reset = 1'b1;
    idle(4);
    send_frame(8'h5A, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0, seen);
    model_push(exp_word(8'h5A, 8'h00, 1'b0, 1'b1));
    idle(2);
    total++;
    if (fifo_count !== 3'(model_q.size())) begin
      bad++; $display("FAIL after_reset_count got=%0d exp=%0d", fifo_count, model_q.size());
    end
    pop_word(w);
    e = model_q.pop_front();
    total++;
    if (w !== e) begin bad++; $display("FAIL after_reset_word got=%h exp=%h", w, e); end
  endtask

  task automatic test_back_to_back;
    logic [7:0] d, o;
    bit         pb;
    for (int i = 0; i < DEPTH; i++) begin
      d = 8'($urandom);
      send_frame(d, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0, seen);
      model_push(exp_word(d, 8'h00, 1'b0, 1'b1));
    end
    for (int i = 0; i < 9; i++) begin
      d  = 8'($urandom);
      o  = 8'($urandom);
      pb = 1'($urandom);
      send_frame(d, o, pb, 1'b1, 1'b1, 1'b0, seen);
      e = model_q.pop_front();
      model_push(exp_word(d, o, pb, 1'b1));
      total++;
      if (seen !== e) begin bad++; $display("FAIL b2b_head%0d got=%h exp=%h", i, seen, e); end
      total++;
      if (fifo_count !== 3'(model_q.size())) begin
        bad++; $display("FAIL b2b_count%0d got=%0d exp=%0d", i, fifo_count, model_q.size());
      end
      total++;
      if (overrun !== model_over) begin
        bad++; $display("FAIL b2b_overrun%0d got=%b exp=%b", i, overrun, model_over);
      end
    end
    idle(2);
    for (int i = 0; i < DEPTH; i++) begin
      pop_word(w);
      e = model_q.pop_front();
      total++;
      if (w !== e) begin bad++; $display("FAIL b2b_drain%0d got=%h exp=%h", i, w, e); end
    end
    total++;
    if (fifo_count !== 3'd0) begin bad++; $display("FAIL b2b_empty got=%0d exp=0", fifo_count); end
  endtask

  task automatic test_random_options;
    logic [7:0] d, o;
    bit         pb;
    for (int i = 0; i < 6; i++) begin
      d  = 8'($urandom);
      o  = 8'($urandom);
      pb = 1'($urandom);
      send_frame(d, o, pb, 1'b1, 1'b0, 1'b1, seen);
      model_push(exp_word(d, o, pb, 1'b1));
      idle($urandom_range(2, 20));
      pop_word(w);
      e = model_q.pop_front();
      total++;
      if (w !== e) begin bad++; $display("FAIL rand_word%0d got=%h exp=%h opts=%h", i, w, e, o); end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_parity();
    test_frame();
    test_overrun();
    test_glitch_reset();
    test_back_to_back();
    test_random_options();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
